// File: rtl/instruction_fetcher_pkg.sv
// Shared types and constants for the instruction fetcher and its queue.
// JAL target prediction helpers exist only when IF_JAL_PREDICT_EN is defined.
package instruction_fetcher_pkg;

   localparam int          DEF_IQ_DEPTH_LOG = 2;
   localparam logic [31:0] DEF_RESET_PC     = 32'h0;

   typedef enum logic {
      S_ISSUE,
      S_WAIT
   } fetch_state_e;

   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] pc;
      logic [31:0] pred_pc;
   } iq_entry_t;

`ifdef IF_JAL_PREDICT_EN
   localparam logic [6:0] OPC_JAL = 7'b1101111;

   // Sign-extended J-type immediate; bit 0 is always zero.
   function automatic logic [31:0] jal_offset(input logic [31:0] inst);
      return {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
   endfunction
`endif

endpackage

// File: rtl/instruction_fetcher_inst_queue.sv
// Circular instruction queue of {inst, pc, pred_pc} entries with push, pop and
// synchronous clear; head entry reads as zero while the queue is empty.
module inst_queue
   import instruction_fetcher_pkg::*;
#(
   parameter int IQ_DEPTH_LOG = DEF_IQ_DEPTH_LOG
) (
   input  logic                  clk_in,
   input  logic                  rst_in,
   input  logic                  clear,
   input  logic                  push,
   input  iq_entry_t             push_entry,
   input  logic                  pop,
   output iq_entry_t             head_entry,
   output logic                  empty,
   output logic                  full,
   output logic [IQ_DEPTH_LOG:0] count
);

   localparam int DEPTH = 1 << IQ_DEPTH_LOG;

   iq_entry_t                 mem [DEPTH];
   logic [IQ_DEPTH_LOG-1:0]   head_q;
   logic [IQ_DEPTH_LOG-1:0]   tail_q;
   logic [IQ_DEPTH_LOG:0]     count_q;
   logic                      push_ok;
   logic                      pop_ok;

   assign empty   = (count_q == '0);
   // Occupancy never exceeds DEPTH, so the MSB alone marks the full state.
   assign full    = count_q[IQ_DEPTH_LOG];
   assign push_ok = push && !full && !clear;
   assign pop_ok  = pop && !empty && !clear;

   // NOTE: storage is left unreset; valid data is tracked by count_q, so resetting it buys nothing.
   always_ff @(posedge clk_in) begin
      if (push_ok) mem[tail_q] <= push_entry;
   end

   // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else if (clear) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         if (push_ok) tail_q <= tail_q + 1'b1;
         if (pop_ok)  head_q <= head_q + 1'b1;
         case ({push_ok, pop_ok})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   assign head_entry = empty ? '0 : mem[head_q];
   assign count      = count_q;

endmodule

// File: rtl/instruction_fetcher.sv
// Front-end fetcher: owns the PC, fetches from a 1-cycle icache and queues results
// for the decoder. Define IF_JAL_PREDICT_EN to predict JAL targets at fetch.
module instruction_fetcher
   import instruction_fetcher_pkg::*;
#(
   parameter int          IQ_DEPTH_LOG = DEF_IQ_DEPTH_LOG,
   parameter logic [31:0] RESET_PC     = DEF_RESET_PC
) (
   input  logic                  clk_in,
   input  logic                  rst_in,
   output logic [31:0]           icache_pc_out,
   input  logic [31:0]           icache_inst_in,
   input  logic                  icache_valid_in,
   output logic                  dec_valid_out,
   input  logic                  dec_ready_in,
   output logic [31:0]           dec_inst_out,
   output logic [31:0]           dec_pc_out,
   output logic [31:0]           dec_pred_pc_out,
   input  logic                  flush_in,
   input  logic [31:0]           flush_pc_in,
   output logic [IQ_DEPTH_LOG:0] iq_count_out
);

   fetch_state_e state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic [31:0]  next_pc;
   logic         iq_empty, iq_full;
   logic         push, pop;
   iq_entry_t    push_entry, head_entry;

   always_comb begin
      next_pc = pc_q + 32'd4;
`ifdef IF_JAL_PREDICT_EN
      if (icache_inst_in[6:0] == OPC_JAL) next_pc = pc_q + jal_offset(icache_inst_in);
`endif
   end

   // A response counts only in S_WAIT, i.e. when pc was stable across the last edge.
   assign push = (state_q == S_WAIT) && icache_valid_in && !iq_full && !flush_in;
   assign pop  = !iq_empty && dec_ready_in && !flush_in;

   assign push_entry = '{inst: icache_inst_in, pc: pc_q, pred_pc: next_pc};

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state_q <= S_ISSUE;
         pc_q    <= RESET_PC;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
      end
   end

   // NOTE: defaults first so every path assigns state_d/pc_d and no latch is inferred.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      if (flush_in) begin
         pc_d    = flush_pc_in & ~32'd3;
         state_d = S_ISSUE;
      end else begin
         case (state_q)
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
               if (push) begin
                  pc_d    = next_pc;
                  state_d = S_ISSUE;
               end
            end
            default: state_d = S_ISSUE;
         endcase
      end
   end

   inst_queue #(
      .IQ_DEPTH_LOG (IQ_DEPTH_LOG)
   ) u_inst_queue (
      .clk_in     (clk_in),
      .rst_in     (rst_in),
      .clear      (flush_in),
      .push       (push),
      .push_entry (push_entry),
      .pop        (pop),
      .head_entry (head_entry),
      .empty      (iq_empty),
      .full       (iq_full),
      .count      (iq_count_out)
   );

   assign icache_pc_out   = pc_q;
   assign dec_valid_out   = !iq_empty;
   assign dec_inst_out    = head_entry.inst;
   assign dec_pc_out      = head_entry.pc;
   assign dec_pred_pc_out = head_entry.pred_pc;

endmodule

// File: tb/tb_instruction_fetcher.sv
// Scoreboard bench for instruction_fetcher: a registered icache model feeds the DUT,
// directed phases queue expected entries and a negedge monitor checks every dequeue.
module tb_instruction_fetcher;
   import instruction_fetcher_pkg::*;

   logic        clk_in = 1'b0;
   logic        rst_in;
   logic [31:0] icache_pc_out;
   logic [31:0] icache_inst_in;
   logic        icache_valid_in;
   logic        dec_valid_out;
   logic        dec_ready_in;
   logic [31:0] dec_inst_out;
   logic [31:0] dec_pc_out;
   logic [31:0] dec_pred_pc_out;
   logic        flush_in;
   logic [31:0] flush_pc_in;
   logic [2:0]  iq_count_out;

   int          checks = 0;
   int          errors = 0;
   logic [95:0] exp_q [$];
   int          cyc;
   logic [31:0] jal_pred;

   instruction_fetcher u_dut (
      .clk_in          (clk_in),
      .rst_in          (rst_in),
      .icache_pc_out   (icache_pc_out),
      .icache_inst_in  (icache_inst_in),
      .icache_valid_in (icache_valid_in),
      .dec_valid_out   (dec_valid_out),
      .dec_ready_in    (dec_ready_in),
      .dec_inst_out    (dec_inst_out),
      .dec_pc_out      (dec_pc_out),
      .dec_pred_pc_out (dec_pred_pc_out),
      .flush_in        (flush_in),
      .flush_pc_in     (flush_pc_in),
      .iq_count_out    (iq_count_out)
   );

   always #5 clk_in = ~clk_in;

   function automatic logic [31:0] model_inst(input logic [31:0] pc);
      if (pc == 32'h0000_0100) return 32'h0100_006F;
      return {pc[24:0], 7'h13};
   endfunction

   function automatic logic [95:0] ent(input logic [31:0] pc, input logic [31:0] pred);
      return {model_inst(pc), pc, pred};
   endfunction

   // icache with one cycle of latency: returns the word for the address seen at the edge.
   always @(posedge clk_in) icache_inst_in <= model_inst(icache_pc_out);

   task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   always @(negedge clk_in) begin
      if (rst_in && dec_valid_out && dec_ready_in && !flush_in) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_pop: got pc %h, required no entry", dec_pc_out);
         end else begin
            check("deq_entry", {dec_inst_out, dec_pc_out, dec_pred_pc_out}, exp_q.pop_front());
         end
      end
   end

   task automatic release_reset();
      repeat (2) @(posedge clk_in);
      @(negedge clk_in);
      rst_in = 1'b1;
   endtask

   task automatic drain(input string name, output int cycles);
      cycles = 0;
      while (exp_q.size() != 0 && cycles < 60) begin
         @(negedge clk_in);
         #1;
         cycles++;
      end
      check(name, exp_q.size(), 0);
   endtask

   task automatic stop_pops();
      @(posedge clk_in);
      #1 dec_ready_in = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: run did not complete, required completion");
      $fatal(1);
   end

   initial begin
      rst_in          = 1'b0;
      icache_valid_in = 1'b1;
      dec_ready_in    = 1'b0;
      flush_in        = 1'b0;
      flush_pc_in     = 32'h0;
`ifdef IF_JAL_PREDICT_EN
      jal_pred = 32'h0000_0110;
`else
      jal_pred = 32'h0000_0104;
`endif

      // Reset state
      repeat (2) @(posedge clk_in);
      #1;
      check("rst_pc", icache_pc_out, 32'h0);
      check("rst_count", iq_count_out, 3'd0);
      check("rst_valid", dec_valid_out, 1'b0);
      check("rst_dec_fields", {dec_inst_out, dec_pc_out, dec_pred_pc_out}, 96'h0);

      // Stream: one push every two cycles, eight entries in order
      for (int i = 0; i < 8; i++) exp_q.push_back(ent(32'(i * 4), 32'(i * 4 + 4)));
      dec_ready_in = 1'b1;
      @(negedge clk_in);
      rst_in = 1'b1;
      drain("stream_drained", cyc);
      check("stream_cycles", cyc, 16);

      // Asynchronous reset mid-run
      #1 rst_in = 1'b0;
      #1;
      check("midrst_pc", icache_pc_out, 32'h0);
      check("midrst_count", iq_count_out, 3'd0);
      check("midrst_valid", dec_valid_out, 1'b0);

      // Full: decoder stalled for 12 cycles, then released
      dec_ready_in = 1'b0;
      for (int i = 0; i < 6; i++) exp_q.push_back(ent(32'(i * 4), 32'(i * 4 + 4)));
      release_reset();
      repeat (12) @(posedge clk_in);
      #1;
      check("full_count", iq_count_out, 3'd4);
      check("full_pc_hold", icache_pc_out, 32'h10);
      dec_ready_in = 1'b1;
      @(posedge clk_in);
      #1;
      check("full_bubble_count", iq_count_out, 3'd3);
      check("full_bubble_pc", icache_pc_out, 32'h10);
      @(posedge clk_in);
      #1;
      check("full_refill_count", iq_count_out, 3'd3);
      check("full_refill_pc", icache_pc_out, 32'h14);
      drain("full_drained", cyc);
      stop_pops();

      // Flush with three entries queued and a push pending
      rst_in = 1'b0;
      release_reset();
      repeat (7) @(posedge clk_in);
      #1;
      check("preflush_count", iq_count_out, 3'd3);
      check("preflush_pc", icache_pc_out, 32'hC);
      flush_in    = 1'b1;
      flush_pc_in = 32'h0000_0203;
      @(posedge clk_in);
      #1 flush_in = 1'b0;
      check("flush_count", iq_count_out, 3'd0);
      check("flush_pc", icache_pc_out, 32'h200);
      check("flush_valid", dec_valid_out, 1'b0);
      @(posedge clk_in);
      #1;
      check("flush_stale_ignored", iq_count_out, 3'd0);
      @(posedge clk_in);
      #1;
      check("flush_first_push", iq_count_out, 3'd1);
      check("flush_next_pc", icache_pc_out, 32'h204);
      exp_q.push_back(ent(32'h200, 32'h204));
      dec_ready_in = 1'b1;
      drain("flush_drained", cyc);
      stop_pops();

      // PC wrap at the top of the address space
      exp_q.push_back(ent(32'hFFFF_FFFC, 32'h0));
      exp_q.push_back(ent(32'h0, 32'h4));
      flush_in     = 1'b1;
      flush_pc_in  = 32'hFFFF_FFFC;
      dec_ready_in = 1'b1;
      @(posedge clk_in);
      #1 flush_in = 1'b0;
      repeat (2) @(posedge clk_in);
      #1;
      check("wrap_next_pc", icache_pc_out, 32'h0);
      drain("wrap_drained", cyc);
      stop_pops();

      // JAL at 0x100: predicted target depends on IF_JAL_PREDICT_EN
      exp_q.push_back({32'h0100_006F, 32'h100, jal_pred});
      exp_q.push_back(ent(jal_pred, jal_pred + 32'd4));
      flush_in     = 1'b1;
      flush_pc_in  = 32'h100;
      dec_ready_in = 1'b1;
      @(posedge clk_in);
      #1 flush_in = 1'b0;
      repeat (2) @(posedge clk_in);
      #1;
      check("jal_next_pc", icache_pc_out, jal_pred);
      drain("jal_drained", cyc);
      stop_pops();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
